fp_div_operand_loader: RTL and testbench
========================================

# fp_div_operand_loader

Byte-serial operand loader and result capture stage placed directly upstream of the combinational `fp_division` block. It assembles two IEEE-754 single-precision operands from an 8-bit valid/ready stream, drives them onto the divider's `in1`/`in2` inputs, and waits a fixed number of cycles for the combinational path to settle. It then registers the divider's `out` together with a divide-by-zero flag and holds the result until the consumer accepts it.

## Interface
- `SETTLE_CYCLES`, default 2: cycles between the last operand byte and result capture; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `byte_in`  in  8  operand byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_sof`  in  1  start-of-frame; marks the current byte as byte 0.
- `byte_ready`  out  1  loader can accept a byte (registered).
- `op_a`  out  32  dividend, wired to `fp_division.in1`.
- `op_b`  out  32  divisor, wired to `fp_division.in2`.
- `div_out`  in  32  quotient from `fp_division.out`.
- `res`  out  32  captured quotient.
- `res_valid`  out  1  `res` and `div_by_zero` are valid.
- `res_ready`  in  1  consumer accepts the result.
- `div_by_zero`  out  1  captured divisor had `op_b[30:0]==0`.
- `busy`  out  1  high in SETTLE and DONE states.

## Operation
- **States.**
  - LOAD: accepting bytes.
  - SETTLE: counting out `SETTLE_CYCLES`.
  - DONE: result held.
- **Byte acceptance.** A byte is accepted on a rising edge where `byte_valid && byte_ready`.
- **Byte index.** A 3-bit counter gives the byte index. An accepted byte with `byte_sof=1` is always index 0, and the following byte is index 1.
- **Byte mapping (MSB first).**
  - Index 0..3 write `op_a[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - Index 4..7 write the same slices of `op_b`.
  - Unwritten bytes keep their previous value. The divider may see mixed operands mid-frame; these are never sampled.
- **LOAD -> SETTLE.** Taken on acceptance of index 7.
  - `byte_ready` falls on that edge.
  - The counter returns to 0.
  - The settle counter loads `SETTLE_CYCLES-1`.
- **SETTLE.** The settle counter decrements each cycle. The transition to DONE happens on the edge where the counter is 0, and on that same edge:
  - `res <= div_out`
  - `div_by_zero <= (op_b[30:0]==0)`
  - `res_valid <= 1`
- **DONE.** `res`, `div_by_zero` and `res_valid` are held stable. On the edge where `res_ready=1`:
  - `res_valid <= 0`
  - `byte_ready <= 1`
  - state returns to LOAD
  - `res` and `div_by_zero` keep their last values.
- **Ignored inputs.** In SETTLE and DONE, `byte_valid` and `byte_sof` are ignored and `op_a`/`op_b` stay frozen.
- **`busy`.** Decoded from the state: 1 in SETTLE and DONE.
- **No arithmetic.** The block does no arithmetic on operands. The divide-by-zero flag covers both +0 and -0 divisors; denormals are not flagged.

## Timing
- **Reset values.**
  - `byte_ready=0`, `res_valid=0`, `busy=0`
  - `op_a=0`, `op_b=0`, `res=0`, `div_by_zero=0`
  - state LOAD, byte index 0.
- **After reset.** `byte_ready` rises on the first rising edge after `rst` deasserts.
- **Latency.** `res_valid` rises exactly `SETTLE_CYCLES` edges after the edge that accepted index 7. The default is 2.
- **Throughput.** The minimum frame period is `8 + SETTLE_CYCLES + 1` cycles when `res_ready` is held high. The first byte of the next frame can be accepted on the edge after the result is consumed.
- **Handshake hold.** `res_valid` stays high with stable data for an unbounded number of cycles while `res_ready=0`.
- **Early `res_ready`.** `res_ready` asserted before `res_valid` has no effect.
- **SOF at index 7.** `byte_sof=1` together with what would be index 7 is treated as index 0; no frame completes.
- **Reset mid-frame or in SETTLE/DONE.** Reset immediately discards all state and returns every output to its reset value. No result is produced for the partial frame.
- **No-valid cycles.** Gaps with `byte_valid=0` in LOAD hold the byte index; there is no timeout.

## Test plan
- **8.0 / 2.0.**
  - Stimulus: reset, then bytes 40 80 00 00 40 00 00 00 (first with sof), real `fp_division` attached, `res_ready=1`.
  - Required: `op_a=0x40800000`, `op_b=0x40000000`, `res=0x40800000`, `div_by_zero=0`, `res_valid` exactly 2 cycles after the last byte.
- **Backpressure.**
  - Stimulus: frame 15.0/5.0 (41 70 00 00 40 A0 00 00) with `res_ready=0` for 6 cycles after `res_valid`, while `byte_valid=1` with junk bytes.
  - Required: `res=0x40400000` stable, `byte_ready=0`, `op_a`/`op_b` unchanged until the `res_ready` edge; `byte_ready=1` on the following cycle.
- **Divide by zero.**
  - Stimulus: frame 3F 80 00 00 80 00 00 00.
  - Required: `div_by_zero=1` with `res_valid`; the next frame 1.0/3.0 gives `div_by_zero=0`.
- **SOF resync.**
  - Stimulus: 3 bytes 11 22 33, then a sof frame for 100.0/25.0 (42 C8 00 00 41 C8 00 00).
  - Required: `op_a=0x42C80000`, `res=0x40800000`, exactly one `res_valid` pulse sequence.
- **Reset mid-operation.**
  - Stimulus: assert `rst` during SETTLE, then deassert.
  - Required: all outputs 0 while in reset, no `res_valid`, and the next full frame 1e6/1e3 (49 74 24 00 44 7A 00 00) gives `res=0x447A0000`.
- **Parameter sweep.**
  - Stimulus: `SETTLE_CYCLES=1` and `15`, back-to-back frames with `res_ready=1`.
  - Required: latency 1 and 15 cycles respectively; frame period 10 and 24 cycles.

Source files
------------

// File: rtl/fp_div_operand_loader.sv
// Byte-serial operand loader for the combinational fp_division block: assembles
// dividend/divisor from a valid/ready byte stream, waits for settle, captures the quotient.
module fp_div_operand_loader #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_sof,
  output logic        byte_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] div_out,
  output logic [31:0] res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        div_by_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  // Sign bit is ignored so that both +0 and -0 divisors are flagged.
  function automatic logic mag_is_zero(input logic [31:0] v);
    return (v[30:0] == 31'd0);
  endfunction

  state_t      state_r, state_s;
  logic [2:0]  idx_r, idx_s, eff_idx_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] op_a_r, op_a_s, op_b_r, op_b_s, res_r, res_s;
  logic        res_valid_r, res_valid_s;
  logic        ready_r, ready_s;
  logic        dbz_r, dbz_s;
  logic        accept_s;

  // Next state, operand byte steering, settle countdown and result capture
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    op_a_s      = op_a_r;
    op_b_s      = op_b_r;
    res_s       = res_r;
    res_valid_s = res_valid_r;
    ready_s     = ready_r;
    dbz_s       = dbz_r;
    accept_s    = byte_valid && ready_r;
    eff_idx_s   = byte_sof ? 3'd0 : idx_r;
    case (state_r)
      ST_LOAD: begin
        ready_s = 1'b1;
        if (accept_s) begin
          case (eff_idx_s)
            3'd0:    op_a_s[31:24] = byte_in;
            3'd1:    op_a_s[23:16] = byte_in;
            3'd2:    op_a_s[15:8]  = byte_in;
            3'd3:    op_a_s[7:0]   = byte_in;
            3'd4:    op_b_s[31:24] = byte_in;
            3'd5:    op_b_s[23:16] = byte_in;
            3'd6:    op_b_s[15:8]  = byte_in;
            3'd7:    op_b_s[7:0]   = byte_in;
            default: op_a_s        = op_a_r;
          endcase
          if (eff_idx_s == 3'd7) begin
            state_s = ST_SETTLE;
            idx_s   = 3'd0;
            cnt_s   = SETTLE_INIT;
            ready_s = 1'b0;
          end else begin
            idx_s = eff_idx_s + 3'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      ST_SETTLE: begin
        ready_s = 1'b0;
        if (cnt_r == 4'd0) begin
          state_s     = ST_DONE;
          res_s       = div_out;
          dbz_s       = mag_is_zero(op_b_r);
          res_valid_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_s     = ST_LOAD;
          res_valid_s = 1'b0;
          ready_s     = 1'b1;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s     = ST_LOAD;
        idx_s       = 3'd0;
        res_valid_s = 1'b0;
        ready_s     = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_LOAD;
      idx_r       <= 3'd0;
      cnt_r       <= 4'd0;
      op_a_r      <= 32'd0;
      op_b_r      <= 32'd0;
      res_r       <= 32'd0;
      res_valid_r <= 1'b0;
      ready_r     <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
      res_r       <= res_s;
      res_valid_r <= res_valid_s;
      ready_r     <= ready_s;
      dbz_r       <= dbz_s;
    end
  end

  assign byte_ready  = ready_r;
  assign op_a        = op_a_r;
  assign op_b        = op_b_r;
  assign res         = res_r;
  assign res_valid   = res_valid_r;
  assign div_by_zero = dbz_r;
  assign busy        = (state_r != ST_LOAD);

endmodule

// File: tb/tb_fp_div_operand_loader.sv
// Randomized self-checking bench: three loaders (settle 2, 1, 15) each fed by a stand-in divider,
// checked against a byte-array operand model and frame-level timing expectations.
module tb_fp_div_operand_loader;

  localparam int NI = 3;

  function automatic int sc_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  // Quotients of the directed operand pairs; other pairs get an arbitrary deterministic mix.
  function automatic logic [31:0] divmodel(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40800000, 32'h40000000}: return 32'h40800000;
      {32'h41700000, 32'h40A00000}: return 32'h40400000;
      {32'h3F800000, 32'h80000000}: return 32'hFF800000;
      {32'h3F800000, 32'h40400000}: return 32'h3EAAAAAB;
      {32'h42C80000, 32'h41C80000}: return 32'h40800000;
      {32'h49742400, 32'h447A0000}: return 32'h447A0000;
      default:                      return a ^ {b[7:0], b[31:8]} ^ 32'h5A5A0F0F;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in     [NI];
  logic        byte_valid  [NI];
  logic        byte_sof    [NI];
  logic        byte_ready  [NI];
  logic [31:0] op_a        [NI];
  logic [31:0] op_b        [NI];
  logic [31:0] div_out     [NI];
  logic [31:0] res         [NI];
  logic        res_valid   [NI];
  logic        res_ready   [NI];
  logic        div_by_zero [NI];
  logic        busy        [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign div_out[g] = divmodel(op_a[g], op_b[g]);
    fp_div_operand_loader #(.SETTLE_CYCLES(sc_of(g))) u_dut (
      .clk(clk), .rst(rst), .byte_in(byte_in[g]), .byte_valid(byte_valid[g]),
      .byte_sof(byte_sof[g]), .byte_ready(byte_ready[g]), .op_a(op_a[g]), .op_b(op_b[g]),
      .div_out(div_out[g]), .res(res[g]), .res_valid(res_valid[g]), .res_ready(res_ready[g]),
      .div_by_zero(div_by_zero[g]), .busy(busy[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] mop [NI][8];
  int         midx    [NI];
  int         drv_cyc [NI];

  task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_a(input int k);
    return {mop[k][0], mop[k][1], mop[k][2], mop[k][3]};
  endfunction

  function automatic logic [31:0] exp_b(input int k);
    return {mop[k][4], mop[k][5], mop[k][6], mop[k][7]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      midx[k] = 0;
      for (int i = 0; i < 8; i++) mop[k][i] = 8'd0;
    end
  endtask

  task automatic check_reset_outputs(input int k);
    check32("rst_byte_ready", 32'(byte_ready[k]), 32'd0);
    check32("rst_res_valid", 32'(res_valid[k]), 32'd0);
    check32("rst_busy", 32'(busy[k]), 32'd0);
    check32("rst_op_a", op_a[k], 32'd0);
    check32("rst_op_b", op_b[k], 32'd0);
    check32("rst_res", res[k], 32'd0);
    check32("rst_dbz", 32'(div_by_zero[k]), 32'd0);
  endtask

  task automatic drive_junk(input int k);
    byte_in[k]    = 8'($urandom);
    byte_valid[k] = 1'b1;
    byte_sof[k]   = 1'($urandom % 2);
  endtask

  // Called at a negedge while the loader should be in LOAD; returns at the next negedge.
  task automatic send_byte(input int k, input logic [7:0] b, input logic s, output bit done);
    int eff;
    check32("byte_ready_load", 32'(byte_ready[k]), 32'd1);
    byte_in[k]    = b;
    byte_valid[k] = 1'b1;
    byte_sof[k]   = s;
    drv_cyc[k]    = cyc;
    @(posedge clk);
    eff = s ? 0 : midx[k];
    mop[k][eff] = b;
    done = (eff == 7);
    midx[k] = done ? 0 : eff + 1;
    @(negedge clk);
    byte_valid[k] = 1'b0;
    byte_sof[k]   = 1'b0;
  endtask

  task automatic finish_frame(input int k, input int hold, input bit junk);
    logic [31:0] ea, eb, er;
    logic        ez;
    int          n, lat;
    ea = exp_a(k);
    eb = exp_b(k);
    er = divmodel(ea, eb);
    ez = (eb[30:0] == 31'd0);
    res_ready[k] = (hold == 0);
    n = 0;
    while (res_valid[k] !== 1'b1 && n < 40) begin
      check32("busy_settle", 32'(busy[k]), 32'd1);
      if (junk) drive_junk(k);
      @(negedge clk);
      n++;
    end
    lat = cyc - drv_cyc[k] - 1;
    check32("latency", 32'(lat), 32'(sc_of(k)));
    check32("res", res[k], er);
    check32("dbz", 32'(div_by_zero[k]), 32'(ez));
    check32("op_a", op_a[k], ea);
    check32("op_b", op_b[k], eb);
    check32("byte_ready_done", 32'(byte_ready[k]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (junk) drive_junk(k);
      @(negedge clk);
      check32("hold_valid", 32'(res_valid[k]), 32'd1);
      check32("hold_res", res[k], er);
      check32("hold_ready", 32'(byte_ready[k]), 32'd0);
      check32("hold_op_a", op_a[k], ea);
      check32("hold_op_b", op_b[k], eb);
    end
    res_ready[k] = 1'b1;
    if (junk) drive_junk(k);
    @(negedge clk);
    byte_valid[k] = 1'b0;
    byte_sof[k]   = 1'b0;
    check32("consume_valid", 32'(res_valid[k]), 32'd0);
    check32("consume_ready", 32'(byte_ready[k]), 32'd1);
    check32("consume_busy", 32'(busy[k]), 32'd0);
    check32("consume_res", res[k], er);
    check32("consume_dbz", 32'(div_by_zero[k]), 32'(ez));
  endtask

  task automatic send_bytes8(input int k, input logic [31:0] a, input logic [31:0] b,
                             input int gapmax);
    logic [63:0] w;
    bit          done;
    w = {a, b};
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && gapmax > 0) repeat ($urandom_range(gapmax, 0)) @(negedge clk);
      send_byte(k, w[63-8*i -: 8], (i == 0), done);
    end
  endtask

  task automatic run_frame(input int k, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit junk, input int gapmax);
    send_bytes8(k, a, b, gapmax);
    finish_frame(k, hold, junk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    bit          done;
    int          start, prev;

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      byte_in[k] = 8'd0; byte_valid[k] = 1'b0; byte_sof[k] = 1'b0; res_ready[k] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) check_reset_outputs(k);
    rst = 1'b0;
    check32("ready_pre_edge", 32'(byte_ready[0]), 32'd0);
    @(negedge clk);
    for (int k = 0; k < NI; k++) check32("ready_post_reset", 32'(byte_ready[k]), 32'd1);

    // Directed frames on the default-settle instance
    run_frame(0, 32'h40800000, 32'h40000000, 0, 1'b0, 0);
    run_frame(0, 32'h41700000, 32'h40A00000, 6, 1'b1, 0);
    run_frame(0, 32'h3F800000, 32'h80000000, 1, 1'b0, 0);
    run_frame(0, 32'h3F800000, 32'h40400000, 0, 1'b0, 0);

    send_byte(0, 8'h11, 1'b0, done);
    send_byte(0, 8'h22, 1'b0, done);
    send_byte(0, 8'h33, 1'b0, done);
    run_frame(0, 32'h42C80000, 32'h41C80000, 0, 1'b0, 0);

    // Seven bytes then a sof byte where index 7 would fall: no frame may complete.
    for (int i = 0; i < 7; i++) send_byte(0, 8'($urandom), 1'b0, done);
    send_byte(0, 8'h3F, 1'b1, done);
    check32("sof7_no_busy", 32'(busy[0]), 32'd0);
    check32("sof7_no_valid", 32'(res_valid[0]), 32'd0);
    send_byte(0, 8'h80, 1'b0, done);
    send_byte(0, 8'h00, 1'b0, done);
    send_byte(0, 8'h00, 1'b0, done);
    send_byte(0, 8'h40, 1'b0, done);
    send_byte(0, 8'h40, 1'b0, done);
    send_byte(0, 8'h00, 1'b0, done);
    send_byte(0, 8'h00, 1'b0, done);
    finish_frame(0, 0, 1'b0);

    // Randomized frames with gaps, stray prefixes, junk and backpressure
    for (int f = 0; f < 30; f++) begin
      ra = $urandom;
      rb = ($urandom_range(3, 0) == 0) ? {1'($urandom % 2), 31'd0} : 32'($urandom);
      if ($urandom_range(3, 0) == 0)
        repeat ($urandom_range(6, 1)) send_byte(0, 8'($urandom), 1'b0, done);
      run_frame(0, ra, rb, $urandom_range(4, 0), 1'($urandom % 2), 3);
    end

    // Reset while settling
    send_bytes8(0, 32'h3F800000, 32'h40400000, 0);
    check32("busy_before_rst", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs(0);
    @(negedge clk);
    check_reset_outputs(0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("no_valid_after_rst", 32'(res_valid[0]), 32'd0);
    end
    check32("ready_after_rst", 32'(byte_ready[0]), 32'd1);
    run_frame(0, 32'h49742400, 32'h447A0000, 0, 1'b0, 0);

    // Back-to-back frames on the settle-1 and settle-15 instances
    for (int k = 1; k < NI; k++) begin
      res_ready[k] = 1'b1;
      prev = 0;
      for (int f = 0; f < 4; f++) begin
        start = cyc;
        run_frame(k, $urandom, $urandom, 0, 1'b0, 0);
        if (f > 0) check32("frame_period", 32'(start - prev), 32'(sc_of(k) + 9));
        prev = start;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
